avr_dmem_arbiter: RTL and testbench

//  Shares the single-port data RAM and IO-register bus between two bus masters: port 0 = avr_cpu

---
 rtl/avr_dmem_arbiter_pkg.sv | 30 +++
 rtl/avr_arb_pick.sv | 25 ++
 rtl/avr_dmem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_avr_dmem_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/avr_dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : avr_dmem_arbiter_pkg
//  Description : Shared bus constants for the AVR data-memory arbiter and any
//                other bus master: IO region limit, port indices and the
//                read-return tag encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package avr_dmem_arbiter_pkg;

    // Addresses below this limit belong to the IO register bus
    localparam logic [15:0] IO_LIMIT_DEFAULT = 16'h0060;

    // Port indices used by the round-robin pointer
    localparam logic ARB_M0 = 1'b0;
    localparam logic ARB_M1 = 1'b1;

    // Source of the data returned one cycle after a granted read
    typedef enum logic {
        TAG_RAM = 1'b0,
        TAG_IO  = 1'b1
    } rd_tag_e;

    // True when a byte address falls in the IO region
    function automatic logic is_io_addr(input logic [15:0] addr, input logic [15:0] limit);
        return (addr < limit);
    endfunction

endpackage : avr_dmem_arbiter_pkg
`default_nettype wire

// File: rtl/avr_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : avr_arb_pick
//  Description : Pure two-way grant selection. A lone request always wins;
//                on contention prio1 decides (1 = port 1 wins). The caller
//                drives prio1 from either the starvation escape or the
//                round-robin pointer (AVR_ARB_RR_EN).
//  Revision    : 1.0  initial release
// ============================================================================
module avr_arb_pick (
    input  logic req0,
    input  logic req1,
    input  logic prio1,
    output logic gnt0,
    output logic gnt1
);

    // One-hot-or-zero grant: port 0 loses only to a prioritised port 1
    always_comb begin
        gnt0 = req0 & (~req1 | ~prio1);
        gnt1 = req1 & (~req0 |  prio1);
    end

endmodule : avr_arb_pick
`default_nettype wire

// File: rtl/avr_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : avr_dmem_arbiter
//  Description : Shares the single-port data RAM and the IO register bus
//                between the CPU data port (m0) and a secondary master (m1).
//                One access per cycle, IO/RAM decode, 1-cycle read return
//                steered back to the master that issued the read.
//                Build option AVR_ARB_RR_EN selects round-robin arbitration
//                instead of fixed m0 priority with MAX_WAIT starvation escape.
//  Revision    : 1.0  initial release
// ============================================================================
module avr_dmem_arbiter
    import avr_dmem_arbiter_pkg::*;
#(
    parameter int          RAMBITS  = 12,
    parameter logic [15:0] IO_LIMIT = IO_LIMIT_DEFAULT,
    parameter int          MAX_WAIT = 8
) (
    input  logic               clk,
    input  logic               reset,
    // port 0 (CPU)
    input  logic               m0_req,
    input  logic               m0_wen,
    input  logic [15:0]        m0_addr,
    input  logic [7:0]         m0_wdata,
    output logic               m0_gnt,
    output logic [7:0]         m0_rdata,
    output logic               m0_rvalid,
    // port 1 (DMA / debug loader)
    input  logic               m1_req,
    input  logic               m1_wen,
    input  logic [15:0]        m1_addr,
    input  logic [7:0]         m1_wdata,
    output logic               m1_gnt,
    output logic [7:0]         m1_rdata,
    output logic               m1_rvalid,
    // RAM side
    output logic [RAMBITS-1:0] ram_addr,
    output logic               ram_wen,
    output logic               ram_ren,
    output logic [7:0]         ram_wdata,
    input  logic [7:0]         ram_rdata,
    // IO side
    output logic [6:0]         io_addr,
    output logic               io_wen,
    output logic               io_ren,
    output logic [7:0]         io_wdata,
    input  logic [7:0]         io_rdata
);

    logic        w_prio1;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_access;
    logic [15:0] w_sel_addr;
    logic        w_sel_wen;
    logic [7:0]  w_sel_wdata;
    logic        w_is_io;
    logic        w_io_acc;
    logic        w_ram_acc;
    logic [7:0]  w_rd_data;

    logic        r_pend0;
    logic        r_pend1;
    rd_tag_e     r_tag;
    logic [7:0]  r_hold0;
    logic [7:0]  r_hold1;

    avr_arb_pick u_pick (
        .req0  (m0_req),
        .req1  (m1_req),
        .prio1 (w_prio1),
        .gnt0  (w_gnt0),
        .gnt1  (w_gnt1)
    );

    assign m0_gnt = w_gnt0;
    assign m1_gnt = w_gnt1;

`ifdef AVR_ARB_RR_EN
    // Pointer names the port that wins the next contention; m0 first after reset
    logic r_rr_ptr;

    // Hand priority to the other port after every grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= ARB_M0;
        end else if (w_gnt0) begin
            r_rr_ptr <= ARB_M1;
        end else if (w_gnt1) begin
            r_rr_ptr <= ARB_M0;
        end
    end

    assign w_prio1 = (r_rr_ptr == ARB_M1);
`else
    localparam logic [7:0] c_max_wait = 8'(MAX_WAIT);
    logic [7:0] r_starve_cnt;

    // Count consecutive denied cycles of m1, saturating at MAX_WAIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= 8'd0;
        end else if (!m1_req || w_gnt1) begin
            r_starve_cnt <= 8'd0;
        end else if (r_starve_cnt != c_max_wait) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end

    // m1 is force-granted once it has waited MAX_WAIT cycles
    assign w_prio1 = (r_starve_cnt == c_max_wait);
`endif

    // Select the winning master's access fields
    always_comb begin
        w_access    = w_gnt0 | w_gnt1;
        w_sel_addr  = w_gnt1 ? m1_addr  : m0_addr;
        w_sel_wen   = w_gnt1 ? m1_wen   : m0_wen;
        w_sel_wdata = w_gnt1 ? m1_wdata : m0_wdata;
        w_is_io     = is_io_addr(w_sel_addr, IO_LIMIT);
        w_io_acc    = w_access &  w_is_io;
        w_ram_acc   = w_access & ~w_is_io;
    end

    // Drive only the addressed slave; the idle one sees all-zero fields
    always_comb begin
        ram_addr  = '0;
        ram_wen   = 1'b0;
        ram_ren   = 1'b0;
        ram_wdata = 8'h00;
        io_addr   = 7'h00;
        io_wen    = 1'b0;
        io_ren    = 1'b0;
        io_wdata  = 8'h00;
        if (w_ram_acc) begin
            ram_addr  = w_sel_addr[RAMBITS-1:0];
            ram_wen   = w_sel_wen;
            ram_ren   = ~w_sel_wen;
            ram_wdata = w_sel_wen ? w_sel_wdata : 8'h00;
        end
        if (w_io_acc) begin
            io_addr  = w_sel_addr[6:0];
            io_wen   = w_sel_wen;
            io_ren   = ~w_sel_wen;
            io_wdata = w_sel_wen ? w_sel_wdata : 8'h00;
        end
    end

    // Remember which master read and from which slave, for next-cycle steering
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend0 <= 1'b0;
            r_pend1 <= 1'b0;
            r_tag   <= TAG_RAM;
        end else begin
            r_pend0 <= w_gnt0 & ~m0_wen;
            r_pend1 <= w_gnt1 & ~m1_wen;
            if (w_access && !w_sel_wen) begin
                r_tag <= w_is_io ? TAG_IO : TAG_RAM;
            end
        end
    end

    assign w_rd_data = (r_tag == TAG_IO) ? io_rdata : ram_rdata;

    // Capture returned data so rdata stays stable between reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold0 <= 8'h00;
            r_hold1 <= 8'h00;
        end else begin
            if (r_pend0) r_hold0 <= w_rd_data;
            if (r_pend1) r_hold1 <= w_rd_data;
        end
    end

    assign m0_rvalid = r_pend0;
    assign m1_rvalid = r_pend1;
    assign m0_rdata  = r_pend0 ? w_rd_data : r_hold0;
    assign m1_rdata  = r_pend1 ? w_rd_data : r_hold1;

endmodule : avr_dmem_arbiter
`default_nettype wire

// File: tb/tb_avr_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_avr_dmem_arbiter
//  Description : Self-checking bench for avr_dmem_arbiter: directed scenarios
//                followed by random two-master traffic against a behavioural
//                model (byte arrays for RAM/IO, integer starve count or
//                last-winner for round-robin under AVR_ARB_RR_EN).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_avr_dmem_arbiter;

    localparam int          RAMBITS  = 12;
    localparam logic [15:0] IO_LIM   = 16'h0060;
    localparam int          MAX_WAIT = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        m0_req, m0_wen, m1_req, m1_wen;
    logic [15:0] m0_addr, m1_addr;
    logic [7:0]  m0_wdata, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [7:0]  m0_rdata, m1_rdata;
    logic [RAMBITS-1:0] ram_addr;
    logic        ram_wen, ram_ren, io_wen, io_ren;
    logic [7:0]  ram_wdata, io_wdata;
    logic [7:0]  ram_rdata = 8'h00;
    logic [7:0]  io_rdata  = 8'h00;
    logic [6:0]  io_addr;

    avr_dmem_arbiter #(.RAMBITS(RAMBITS), .IO_LIMIT(IO_LIM), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .ram_addr(ram_addr), .ram_wen(ram_wen), .ram_ren(ram_ren),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .io_addr(io_addr), .io_wen(io_wen), .io_ren(io_ren),
        .io_wdata(io_wdata), .io_rdata(io_rdata)
    );

    // Slave devices: registered read data, 1-cycle latency
    logic [7:0] ram_arr [0:4095];
    logic [7:0] io_arr  [0:127];
    always @(posedge clk) begin
        if (ram_wen) ram_arr[ram_addr] <= ram_wdata;
        if (ram_ren) ram_rdata <= ram_arr[ram_addr];
        if (io_wen)  io_arr[io_addr] <= io_wdata;
        if (io_ren)  io_rdata <= io_arr[io_addr];
    end

    // Reference model state
    logic [7:0] ref_mem [0:4095];
    logic [7:0] ref_io  [0:127];
    int         starve;
    int         last_gnt;
    bit         pend [2];
    logic [7:0] pend_data [2];
    logic [7:0] hold [2];
    int         winner;
    bit         got0, got1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        starve   = 0;
        last_gnt = 1;       // so m0 wins the first round-robin contention
        pend[0]  = 0;
        pend[1]  = 0;
        hold[0]  = 8'h00;
        hold[1]  = 8'h00;
    endtask

    task automatic set_m(input int p, input bit req, input bit wen,
                         input logic [15:0] addr, input logic [7:0] wdata);
        if (p == 0) begin
            m0_req = req; m0_wen = wen; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_wen = wen; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    // One clock cycle: check comb outputs and returns at negedge, advance model,
    // then leave the caller just after the rising edge to drive new inputs.
    task automatic step();
        bit          r0, r1, w1, g0, g1, any, io, ram, wen;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          ridx;
        @(negedge clk);
        r0 = m0_req;
        r1 = m1_req;
`ifdef AVR_ARB_RR_EN
        w1 = (r0 && r1) ? (last_gnt == 0) : r1;
`else
        w1 = (r0 && r1) ? (starve >= MAX_WAIT) : r1;
`endif
        g0    = r0 && !w1;
        g1    = r1 && w1;
        any   = g0 || g1;
        addr  = g1 ? m1_addr  : m0_addr;
        wen   = g1 ? m1_wen   : m0_wen;
        wdata = g1 ? m1_wdata : m0_wdata;
        io    = any && (addr < IO_LIM);
        ram   = any && !io;
        ridx  = int'(addr) % 4096;

        check("gnt0",      m0_gnt,    g0);
        check("gnt1",      m1_gnt,    g1);
        check("ram_wen",   ram_wen,   ram && wen);
        check("ram_ren",   ram_ren,   ram && !wen);
        check("io_wen",    io_wen,    io && wen);
        check("io_ren",    io_ren,    io && !wen);
        check("ram_addr",  ram_addr,  ram ? ridx : 0);
        check("io_addr",   io_addr,   io ? int'(addr) % 128 : 0);
        check("ram_wdata", ram_wdata, (ram && wen) ? wdata : 8'h00);
        check("io_wdata",  io_wdata,  (io && wen) ? wdata : 8'h00);
        check("rvalid0",   m0_rvalid, pend[0]);
        check("rvalid1",   m1_rvalid, pend[1]);
        check("rdata0",    m0_rdata,  pend[0] ? pend_data[0] : hold[0]);
        check("rdata1",    m1_rdata,  pend[1] ? pend_data[1] : hold[1]);

        for (int p = 0; p < 2; p++) begin
            if (pend[p]) hold[p] = pend_data[p];
            pend[p] = 0;
        end
        winner = any ? (g1 ? 1 : 0) : -1;
        if (any && !wen) begin
            pend[winner]      = 1;
            pend_data[winner] = io ? ref_io[int'(addr) % 128] : ref_mem[ridx];
        end
        if (any && wen) begin
            if (io) ref_io[int'(addr) % 128] = wdata;
            else    ref_mem[ridx] = wdata;
        end
        if (!r1 || g1)              starve = 0;
        else if (starve < MAX_WAIT) starve++;
        if (any) last_gnt = winner;
        got0 = g0;
        got1 = g1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_addr();
        logic [15:0] base;
        case ($urandom_range(0, 5))
            0:       base = 16'h0038;
            1:       base = 16'h0058;   // last IO bytes up to 0x5F
            2:       base = 16'h0060;   // first RAM bytes
            3:       base = 16'h0100;
            4:       base = 16'h1100;   // aliases 0x100
            default: base = 16'hF100;   // aliases 0x100
        endcase
        return base + 16'($urandom_range(0, 7));
    endfunction

    int wins[$];
    int m1_idx[$];

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram_arr[i] = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        for (int i = 0; i < 128; i++) begin
            io_arr[i] = 8'(i ^ 8'hC3);
            ref_io[i] = 8'(i ^ 8'hC3);
        end
        model_reset();
        got0 = 0; got1 = 0;
        reset = 1'b1;
        set_m(0, 0, 0, 16'h0, 8'h0);
        set_m(1, 0, 0, 16'h0, 8'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rvalid0", m0_rvalid, 0);
        check("rst_rvalid1", m1_rvalid, 0);
        check("rst_strobes", {ram_wen, ram_ren, io_wen, io_ren, m0_gnt, m1_gnt}, 0);
        check("rst_ram_addr", ram_addr, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // RAM write then read-back on m0
        set_m(0, 1, 1, 16'h0100, 8'hA5); step();
        set_m(0, 1, 0, 16'h0100, 8'h00); step();
        set_m(0, 0, 0, 16'h0000, 8'h00); step();
        check("t1_rdata", m0_rdata, 8'hA5);

        // IO write then read-back on m0
        set_m(0, 1, 1, 16'h0038, 8'h3C); step();
        set_m(0, 1, 0, 16'h0038, 8'h00); step();
        set_m(0, 0, 0, 16'h0000, 8'h00); step();
        check("t2_rdata", m0_rdata, 8'h3C);

        // m1 read through an aliased address lands on 0x100
        set_m(1, 1, 0, 16'h1100, 8'h00); step();
        set_m(1, 0, 0, 16'h0000, 8'h00); step();
        check("t4_rdata", m1_rdata, 8'hA5);

        // Contention with both requests held
        set_m(0, 1, 0, 16'h0104, 8'h00);
        set_m(1, 1, 0, 16'hF105, 8'h00);
        for (int i = 0; i < 20; i++) begin
            step();
            wins.push_back(winner);
            if (winner == 1) m1_idx.push_back(i);
        end
`ifdef AVR_ARB_RR_EN
        for (int i = 0; i < 4; i++) check("t3_rr_order", wins[i], i % 2);
`else
        check("t3_first_m1",  m1_idx.size() > 0 ? m1_idx[0] : -1, MAX_WAIT);
        check("t3_second_m1", m1_idx.size() > 1 ? m1_idx[1] : -1, 2 * MAX_WAIT + 1);
`endif
        set_m(0, 0, 0, 16'h0, 8'h0);
        set_m(1, 0, 0, 16'h0, 8'h0);
        step();

        // Read in flight when reset hits: the return must be suppressed
        set_m(0, 1, 0, 16'h0100, 8'h00);
        @(negedge clk);
        check("t5_gnt", m0_gnt, 1);
        reset = 1'b1;
        set_m(0, 0, 0, 16'h0, 8'h0);
        @(posedge clk);
        #1;
        check("t5_rvalid", m0_rvalid, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        step();

        // Random traffic; a denied master keeps its request unchanged
        for (int c = 0; c < 600; c++) begin
            if (!(m0_req && !got0))
                set_m(0, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, rand_addr(), 8'($urandom));
            if (!(m1_req && !got1))
                set_m(1, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, rand_addr(), 8'($urandom));
            step();
        end
        set_m(0, 0, 0, 16'h0, 8'h0);
        set_m(1, 0, 0, 16'h0, 8'h0);
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_avr_dmem_arbiter
`default_nettype wire
